// File: rtl/calc_ctrl.sv
// Calculator sequencer: keypad command handshake, operand entry, signed
// accumulator with pending operator, 1-cycle add/sub and DW-cycle shift-add
// multiply, plus registered display outputs for the digit-split logic.
module calc_ctrl #(
   parameter int DW         = 27,
   parameter int MAX_DIGITS = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          cmd_valid,
   input  logic [3:0]    cmd,
   output logic          cmd_ready,
   output logic [1:0]    status,
   output logic [DW-1:0] digits,
   output logic          neg,
   output logic [3:0]    pos
);

   localparam int CW = $clog2(DW + 1);
   localparam logic [2*DW-1:0] MAX_VAL = (2*DW)'(10**MAX_DIGITS - 1);

   localparam logic [3:0] CMD_ADD   = 4'hA;
   localparam logic [3:0] CMD_SUB   = 4'hB;
   localparam logic [3:0] CMD_MUL   = 4'hC;
   localparam logic [3:0] CMD_EQ    = 4'hE;
   localparam logic [3:0] CMD_ERASE = 4'hF;

   localparam logic [1:0] ST_ENTRY  = 2'b00;
   localparam logic [1:0] ST_BUSY   = 2'b01;
   localparam logic [1:0] ST_RESULT = 2'b10;
   localparam logic [1:0] ST_ERROR  = 2'b11;

   typedef enum logic [2:0] {S_ENTRY_A, S_ENTRY_B, S_EXEC, S_MUL, S_SHOW, S_ERR} state_t;
   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;

   state_t            state;
   op_t               op, nxt_op, cmd_op;
   logic              after_eq;
   logic [DW-1:0]     entry, acc_mag, mplier, entry_dig;
   logic              acc_neg;
   logic [2*DW-1:0]   mcand, prod, mul_next;
   logic [CW-1:0]     cnt;

   logic              accept, is_digit, is_op, go_exec, fin_now, fin_neg, overflow;
   logic signed [DW+1:0] acc_s, entry_s, sum_s;
   logic [DW+1:0]     sum_abs;
   logic [2*DW-1:0]   fin_mag;

   // Command decode, add/sub result, multiply step and completion detection.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      cmd_op    = OP_ADD;
      if (cmd == CMD_SUB) cmd_op = OP_SUB;
      if (cmd == CMD_MUL) cmd_op = OP_MUL;
      accept    = cmd_valid & cmd_ready;
      is_digit  = (cmd <= 4'd9);
      is_op     = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_MUL);
      entry_dig = entry * DW'(10) + DW'(cmd);
      // Entry at pos=0 is always 0, so '=' with nothing typed computes acc op 0.
      go_exec   = accept && (state == S_ENTRY_B) &&
                  ((is_op && pos != 4'd0) || cmd == CMD_EQ);

      acc_s     = $signed({2'b00, acc_mag});
      if (acc_neg) acc_s = -acc_s;
      entry_s   = $signed({2'b00, entry});
      sum_s     = (op == OP_SUB) ? acc_s - entry_s : acc_s + entry_s;
      sum_abs   = sum_s[DW+1] ? $unsigned(-sum_s) : $unsigned(sum_s);

      mul_next  = prod + (mplier[0] ? mcand : '0);

      fin_now   = (state == S_EXEC) || (state == S_MUL && cnt == CW'(1));
      fin_mag   = (state == S_MUL) ? mul_next : {{(DW-2){1'b0}}, sum_abs};
      // A zero magnitude is never shown as negative.
      fin_neg   = ((state == S_MUL) ? acc_neg : sum_s[DW+1]) && (fin_mag != '0);
      overflow  = fin_mag > MAX_VAL;
   end

   // Sequencer: state, operands, multiplier datapath and registered display outputs.
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
      if (!reset) begin
         state     <= S_ENTRY_A;
         op        <= OP_ADD;
         nxt_op    <= OP_ADD;
         after_eq  <= 1'b0;
         entry     <= '0;
         pos       <= '0;
         acc_mag   <= '0;
         acc_neg   <= 1'b0;
         mcand     <= '0;
         mplier    <= '0;
         prod      <= '0;
         cnt       <= '0;
         cmd_ready <= 1'b1;
         status    <= ST_ENTRY;
         digits    <= '0;
         neg       <= 1'b0;
      end else begin
         case (state)
            S_ENTRY_A, S_ENTRY_B: begin
               if (go_exec) begin
                  after_eq  <= (cmd == CMD_EQ);
                  nxt_op    <= is_op ? cmd_op : op;
                  cmd_ready <= 1'b0;
                  status    <= ST_BUSY;
                  if (op == OP_MUL) begin
                     state  <= S_MUL;
                     mcand  <= {{DW{1'b0}}, acc_mag};
                     mplier <= entry;
                     prod   <= '0;
                     cnt    <= CW'(DW);
                  end else begin
                     state  <= S_EXEC;
                  end
               end else if (accept) begin
                  if (is_digit) begin
                     // Leading zeros are swallowed so pos counts significant digits only.
                     if (pos < 4'(MAX_DIGITS) && !(entry == '0 && cmd == 4'd0)) begin
                        entry  <= entry_dig;
                        pos    <= pos + 4'd1;
                        digits <= entry_dig;
                     end
                  end else if (is_op) begin
                     if (state == S_ENTRY_A) begin
                        acc_mag <= entry;
                        acc_neg <= 1'b0;
                        op      <= cmd_op;
                        entry   <= '0;
                        pos     <= '0;
                        digits  <= '0;
                        state   <= S_ENTRY_B;
                     end else begin
                        op      <= cmd_op;
                     end
                  end else if (cmd == CMD_ERASE && pos != 4'd0) begin
                     entry  <= entry / DW'(10);
                     pos    <= pos - 4'd1;
                     digits <= entry / DW'(10);
                  end
               end
            end

            S_EXEC, S_MUL: begin
               if (fin_now) begin
                  cmd_ready <= 1'b1;
                  entry     <= '0;
                  pos       <= '0;
                  if (overflow) begin
                     state   <= S_ERR;
                     status  <= ST_ERROR;
                     digits  <= '0;
                     neg     <= 1'b0;
                     acc_mag <= '0;
                     acc_neg <= 1'b0;
                  end else begin
                     acc_mag <= fin_mag[DW-1:0];
                     acc_neg <= fin_neg;
                     if (after_eq) begin
                        state  <= S_SHOW;
                        status <= ST_RESULT;
                        digits <= fin_mag[DW-1:0];
                        neg    <= fin_neg;
                     end else begin
                        state  <= S_ENTRY_B;
                        status <= ST_ENTRY;
                        op     <= nxt_op;
                        digits <= '0;
                        neg    <= 1'b0;
                     end
                  end
               end else begin
                  prod   <= mul_next;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  cnt    <= cnt - CW'(1);
               end
            end

            S_SHOW: begin
               if (accept) begin
                  if (is_digit) begin
                     entry   <= DW'(cmd);
                     pos     <= (cmd != 4'd0) ? 4'd1 : 4'd0;
                     acc_mag <= '0;
                     acc_neg <= 1'b0;
                     digits  <= DW'(cmd);
                     neg     <= 1'b0;
                     status  <= ST_ENTRY;
                     state   <= S_ENTRY_A;
                  end else if (is_op) begin
                     op      <= cmd_op;
                     digits  <= '0;
                     neg     <= 1'b0;
                     status  <= ST_ENTRY;
                     state   <= S_ENTRY_B;
                  end else if (cmd == CMD_ERASE) begin
                     acc_mag <= '0;
                     acc_neg <= 1'b0;
                     op      <= OP_ADD;
                     digits  <= '0;
                     neg     <= 1'b0;
                     status  <= ST_ENTRY;
                     state   <= S_ENTRY_A;
                  end
               end
            end

            S_ERR: begin
               if (accept && cmd == CMD_ERASE) begin
                  op     <= OP_ADD;
                  digits <= '0;
                  neg    <= 1'b0;
                  status <= ST_ENTRY;
                  state  <= S_ENTRY_A;
               end
            end

            default: state <= S_ENTRY_A;
         endcase
      end
   end

endmodule
